// File: rtl/mipi_csi_pkt_sequencer.sv
// CSI-2 packet sequencer: parses merged lane words, gates RAW10 payload to the unpacker,
// and generates frame/line sync and counters. Define MIPI_ECC_CHECK_EN to enable header ECC checking.
module mipi_csi_pkt_sequencer #(
  parameter logic [1:0]  VC_SEL = 2'd0,
  parameter logic [5:0]  DT_SEL = 6'h2B,
  parameter logic [15:0] MAX_WC = 16'd4000,
  parameter int          LINE_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              in_valid_i,
  input  logic              in_sot_i,
  input  logic [31:0]       in_data_i,
  output logic              pay_valid_o,
  output logic [31:0]       pay_data_o,
  output logic [2:0]        pay_bytes_o,
  output logic              pay_last_o,
  output logic              fsync_o,
  output logic              lsync_o,
  output logic [15:0]       frame_cnt_o,
  output logic [LINE_W-1:0] line_cnt_o,
  output logic              err_ecc_o,
  output logic              err_len_o,
  output logic              err_trunc_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, PAY, SKIP} state_t;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;

  state_t              r_state;
  logic [16:0]         r_rem;
  logic                r_pay_valid;
  logic [31:0]         r_pay_data;
  logic [2:0]          r_pay_bytes;
  logic                r_pay_last;
  logic                r_fsync;
  logic                r_lsync;
  logic [15:0]         r_frame_cnt;
  logic [LINE_W-1:0]   r_line_cnt;
  logic                r_err_ecc;
  logic                r_err_len;
  logic                r_err_trunc;

  logic [1:0]  w_vc;
  logic [5:0]  w_dt;
  logic [15:0] w_wc;
  logic        w_is_short;
  logic [16:0] w_wc_p2;
  logic [16:0] w_avail;
  logic [2:0]  w_pbytes;
  logic        w_last;
  logic [16:0] w_rem_next;
  logic        w_ecc_bad;

  assign w_dt       = in_data_i[5:0];
  assign w_vc       = in_data_i[7:6];
  assign w_wc       = in_data_i[23:8];
  assign w_is_short = (w_dt <= 6'h0F);
  assign w_wc_p2    = {1'b0, w_wc} + 17'd2;

  // rem counts payload bytes plus the two CRC bytes still to come
  assign w_avail    = (r_rem > 17'd2) ? (r_rem - 17'd2) : 17'd0;
  assign w_pbytes   = (w_avail >= 17'd4) ? 3'd4 : w_avail[2:0];
  assign w_last     = (r_rem <= 17'd6);
  assign w_rem_next = (r_rem > 17'd4) ? (r_rem - 17'd4) : 17'd0;

`ifdef MIPI_ECC_CHECK_EN
  logic [5:0] w_ecc_calc;
  assign w_ecc_calc[0] = ^(in_data_i[23:0] & 24'hF12CB7);
  assign w_ecc_calc[1] = ^(in_data_i[23:0] & 24'hF2555B);
  assign w_ecc_calc[2] = ^(in_data_i[23:0] & 24'h749A6D);
  assign w_ecc_calc[3] = ^(in_data_i[23:0] & 24'hB8E38E);
  assign w_ecc_calc[4] = ^(in_data_i[23:0] & 24'hDF03F0);
  assign w_ecc_calc[5] = ^(in_data_i[23:0] & 24'hEFFC00);
  assign w_ecc_bad     = (w_ecc_calc != in_data_i[29:24]);
`else
  assign w_ecc_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_pay_valid <= 1'b0;
      r_pay_data  <= '0;
      r_pay_bytes <= '0;
      r_pay_last  <= 1'b0;
      r_fsync     <= 1'b0;
      r_lsync     <= 1'b0;
      r_frame_cnt <= '0;
      r_line_cnt  <= '0;
      r_err_ecc   <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_trunc <= 1'b0;
    end else begin
      r_pay_valid <= 1'b0;
      r_pay_bytes <= '0;
      r_pay_last  <= 1'b0;
      r_err_ecc   <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_trunc <= 1'b0;
      if (in_valid_i) begin
        if (in_sot_i) begin
          // a header always aborts whatever packet was in flight, then is decoded normally
          if (r_state != IDLE) begin
            r_err_trunc <= 1'b1;
            if (r_state == PAY) r_lsync <= 1'b0;
          end
          r_state <= IDLE;
          if (enable_i) begin
            if (w_ecc_bad) begin
              r_err_ecc <= 1'b1;
              if (!w_is_short) begin
                r_rem   <= w_wc_p2;
                r_state <= SKIP;
              end
            end else if (w_is_short) begin
              if (w_vc == VC_SEL) begin
                case (w_dt)
                  DT_FS: begin
                    r_fsync     <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_line_cnt  <= '0;
                  end
                  DT_FE:   r_fsync <= 1'b0;
                  default: ;
                endcase
              end
            end else if (w_wc > MAX_WC) begin
              r_err_len <= 1'b1;
              r_rem     <= w_wc_p2;
              r_state   <= SKIP;
            end else if ((w_vc == VC_SEL) && (w_dt == DT_SEL)) begin
              r_rem   <= w_wc_p2;
              r_state <= PAY;
              r_lsync <= 1'b1;
            end else begin
              r_rem   <= w_wc_p2;
              r_state <= SKIP;
            end
          end
        end else if (r_state != IDLE) begin
          if (r_state == PAY) begin
            if (w_pbytes != 3'd0) begin
              r_pay_valid <= 1'b1;
              r_pay_data  <= in_data_i;
              r_pay_bytes <= w_pbytes;
              r_pay_last  <= w_last;
            end
            // lsync still high marks the line end not yet counted (also covers WC = 0)
            if (r_lsync && w_last) begin
              r_lsync    <= 1'b0;
              r_line_cnt <= r_line_cnt + LINE_W'(1);
            end
          end
          r_rem <= w_rem_next;
          if (w_rem_next == 17'd0) r_state <= IDLE;
        end
      end
    end
  end

  assign pay_valid_o = r_pay_valid;
  assign pay_data_o  = r_pay_data;
  assign pay_bytes_o = r_pay_bytes;
  assign pay_last_o  = r_pay_last;
  assign fsync_o     = r_fsync;
  assign lsync_o     = r_lsync;
  assign frame_cnt_o = r_frame_cnt;
  assign line_cnt_o  = r_line_cnt;
  assign err_ecc_o   = r_err_ecc;
  assign err_len_o   = r_err_len;
  assign err_trunc_o = r_err_trunc;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_mipi_csi_pkt_sequencer.sv
// Directed, table-driven bench for mipi_csi_pkt_sequencer (default parameters).
// Honours MIPI_ECC_CHECK_EN for the header ECC corner case.
module tb_mipi_csi_pkt_sequencer;

  localparam logic [5:0] RAW10 = 6'h2B;
  localparam logic [5:0] RAW8  = 6'h2A;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic        inValid;
  logic        inSot;
  logic [31:0] inData;
  logic        payValid;
  logic [31:0] payData;
  logic [2:0]  payBytes;
  logic        payLast;
  logic        fsync;
  logic        lsync;
  logic [15:0] frameCnt;
  logic [11:0] lineCnt;
  logic        errEcc;
  logic        errLen;
  logic        errTrunc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mipi_csi_pkt_sequencer dut (
    .clk_i       (clk),
    .rst_n_i     (rstN),
    .enable_i    (enable),
    .in_valid_i  (inValid),
    .in_sot_i    (inSot),
    .in_data_i   (inData),
    .pay_valid_o (payValid),
    .pay_data_o  (payData),
    .pay_bytes_o (payBytes),
    .pay_last_o  (payLast),
    .fsync_o     (fsync),
    .lsync_o     (lsync),
    .frame_cnt_o (frameCnt),
    .line_cnt_o  (lineCnt),
    .err_ecc_o   (errEcc),
    .err_len_o   (errLen),
    .err_trunc_o (errTrunc),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        v;
    logic        s;
    logic        e;
    logic [31:0] data;
    logic        pv;
    logic [2:0]  bytes;
    logic        last;
    logic        fs;
    logic        ls;
    logic [15:0] frame;
    logic [11:0] line;
    logic        elen;
    logic        etrunc;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] eccOf(logic [23:0] d);
    logic [7:0] p;
    p    = 8'h00;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  function automatic logic [31:0] hdr(logic [1:0] vc, logic [5:0] dt, logic [15:0] wc);
    logic [23:0] h;
    h = {wc, vc, dt};
    return {eccOf(h), h};
  endfunction

  function automatic vec_t mk(logic v, logic s, logic e, logic [31:0] data,
                              logic pv, logic [2:0] bytes, logic last, logic fs, logic ls,
                              logic [15:0] frame, logic [11:0] line, logic elen,
                              logic etrunc, logic bsy);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.data = data;
    r.pv = pv; r.bytes = bytes; r.last = last; r.fs = fs; r.ls = ls;
    r.frame = frame; r.line = line; r.elen = elen; r.etrunc = etrunc; r.busy = bsy;
    return r;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one word half a cycle before the capturing edge, then settle just after it
  task automatic applyStimulus(input logic v, input logic s, input logic e, input logic [31:0] d);
    @(negedge clk);
    inValid = v;
    inSot   = s;
    enable  = e;
    inData  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t x, input int idx);
    checkField($sformatf("v%0d.payValid", idx), payValid, x.pv);
    checkField($sformatf("v%0d.payBytes", idx), payBytes, x.bytes);
    checkField($sformatf("v%0d.payLast", idx), payLast, x.last);
    if (x.pv) checkField($sformatf("v%0d.payData", idx), payData, x.data);
    checkField($sformatf("v%0d.fsync", idx), fsync, x.fs);
    checkField($sformatf("v%0d.lsync", idx), lsync, x.ls);
    checkField($sformatf("v%0d.frameCnt", idx), frameCnt, x.frame);
    checkField($sformatf("v%0d.lineCnt", idx), lineCnt, x.line);
    checkField($sformatf("v%0d.errLen", idx), errLen, x.elen);
    checkField($sformatf("v%0d.errTrunc", idx), errTrunc, x.etrunc);
    checkField($sformatf("v%0d.errEcc", idx), errEcc, 1'b0);
    checkField($sformatf("v%0d.busy", idx), busy, x.busy);
  endtask

  initial begin
    int pvCount;
    int byteSum;
    int lastCount;
    int waitCycles;
    logic [31:0] badFs;

    rstN = 1'b0; enable = 1'b0; inValid = 1'b0; inSot = 1'b0; inData = '0;

    // Columns: valid sot enable data | payValid bytes last fsync lsync frame line errLen errTrunc busy
    vecs.push_back(mk(1,1,1, hdr(0,6'h00,0),  0,0,0, 1,0, 1,0, 0,0,0)); // FS
    vecs.push_back(mk(1,1,1, hdr(0,6'h01,0),  0,0,0, 0,0, 1,0, 0,0,0)); // FE
    vecs.push_back(mk(1,0,1, 32'h12345678,    0,0,0, 0,0, 1,0, 0,0,0)); // stray word in IDLE
    vecs.push_back(mk(1,1,1, hdr(0,6'h00,0),  0,0,0, 1,0, 2,0, 0,0,0)); // FS
    vecs.push_back(mk(1,1,1, hdr(0,6'h02,0),  0,0,0, 1,0, 2,0, 0,0,0)); // LS no action
    vecs.push_back(mk(1,1,1, hdr(0,RAW10,10), 0,0,0, 1,1, 2,0, 0,0,1)); // RAW10 WC=10
    vecs.push_back(mk(1,0,1, 32'h03020100,    1,4,0, 1,1, 2,0, 0,0,1));
    vecs.push_back(mk(1,0,1, 32'h07060504,    1,4,0, 1,1, 2,0, 0,0,1));
    vecs.push_back(mk(1,0,1, 32'hCCCC0908,    1,2,1, 1,0, 2,1, 0,0,0));
    vecs.push_back(mk(0,0,1, 32'h0,           0,0,0, 1,0, 2,1, 0,0,0)); // idle cycle
    vecs.push_back(mk(1,1,1, hdr(0,RAW8,8),   0,0,0, 1,0, 2,1, 0,0,1)); // RAW8 skipped
    vecs.push_back(mk(1,0,1, 32'hAAAAAAAA,    0,0,0, 1,0, 2,1, 0,0,1));
    vecs.push_back(mk(1,0,1, 32'hBBBBBBBB,    0,0,0, 1,0, 2,1, 0,0,1));
    vecs.push_back(mk(1,0,1, 32'hCCCCCCCC,    0,0,0, 1,0, 2,1, 0,0,0));
    vecs.push_back(mk(1,1,1, hdr(0,RAW10,8),  0,0,0, 1,1, 2,1, 0,0,1)); // RAW10 WC=8
    vecs.push_back(mk(1,0,1, 32'h11111111,    1,4,0, 1,1, 2,1, 0,0,1));
    vecs.push_back(mk(1,0,1, 32'h22222222,    1,4,1, 1,0, 2,2, 0,0,1));
    vecs.push_back(mk(1,0,1, 32'h33333333,    0,0,0, 1,0, 2,2, 0,0,0)); // CRC-only word
    vecs.push_back(mk(1,1,1, hdr(0,RAW10,0),  0,0,0, 1,1, 2,2, 0,0,1)); // WC=0
    vecs.push_back(mk(1,0,1, 32'h44444444,    0,0,0, 1,0, 2,3, 0,0,0));
    vecs.push_back(mk(1,1,1, hdr(1,RAW10,4),  0,0,0, 1,0, 2,3, 0,0,1)); // other VC
    vecs.push_back(mk(1,0,1, 32'h55555555,    0,0,0, 1,0, 2,3, 0,0,1));
    vecs.push_back(mk(1,0,1, 32'h66666666,    0,0,0, 1,0, 2,3, 0,0,0));
    vecs.push_back(mk(1,1,1, hdr(0,RAW10,16'h2000), 0,0,0, 1,0, 2,3, 1,0,1)); // too long
    vecs.push_back(mk(1,0,1, 32'h77777777,    0,0,0, 1,0, 2,3, 0,0,1));
    vecs.push_back(mk(1,1,1, hdr(0,RAW10,40), 0,0,0, 1,1, 2,3, 0,1,1)); // truncates SKIP
    vecs.push_back(mk(1,0,1, 32'hAAAA5555,    1,4,0, 1,1, 2,3, 0,0,1));
    vecs.push_back(mk(1,1,1, hdr(0,6'h01,0),  0,0,0, 0,0, 2,3, 0,1,0)); // FE truncates PAY
    vecs.push_back(mk(1,1,1, hdr(1,6'h00,0),  0,0,0, 0,0, 2,3, 0,0,0)); // FS on VC1
    vecs.push_back(mk(1,1,0, hdr(0,6'h00,0),  0,0,0, 0,0, 2,3, 0,0,0)); // FS disabled
    vecs.push_back(mk(1,1,1, hdr(0,RAW10,4),  0,0,0, 0,1, 2,3, 0,0,1));
    vecs.push_back(mk(1,0,0, 32'h88888888,    1,4,1, 0,0, 2,4, 0,0,1)); // enable drops mid-packet
    vecs.push_back(mk(1,0,0, 32'h99999999,    0,0,0, 0,0, 2,4, 0,0,0));
    vecs.push_back(mk(1,1,0, hdr(0,RAW10,4),  0,0,0, 0,0, 2,4, 0,0,0)); // header ignored
    vecs.push_back(mk(1,1,1, hdr(0,6'h00,0),  0,0,0, 1,0, 3,0, 0,0,0)); // FS
    vecs.push_back(mk(1,1,1, hdr(0,RAW10,0),  0,0,0, 1,1, 3,0, 0,0,1));
    vecs.push_back(mk(1,0,1, 32'hDDDDDDDD,    0,0,0, 1,0, 3,1, 0,0,0));
    vecs.push_back(mk(1,1,1, hdr(0,6'h00,0),  0,0,0, 1,0, 4,0, 0,0,0)); // FS with FE lost
    vecs.push_back(mk(1,1,1, hdr(0,RAW10,1),  0,0,0, 1,1, 4,0, 0,0,1)); // WC=1
    vecs.push_back(mk(1,0,1, 32'hEEEEEEAB,    1,1,1, 1,0, 4,1, 0,0,0));
    vecs.push_back(mk(1,1,1, hdr(1,RAW8,4000),0,0,0, 1,0, 4,1, 0,0,1)); // WC = MAX_WC legal
    vecs.push_back(mk(1,1,1, hdr(1,RAW8,4001),0,0,0, 1,0, 4,1, 1,1,1)); // WC = MAX_WC+1
    vecs.push_back(mk(1,1,1, hdr(0,6'h00,0),  0,0,0, 1,0, 5,0, 0,1,0)); // FS truncates SKIP
    vecs.push_back(mk(0,0,1, 32'h0,           0,0,0, 1,0, 5,0, 0,0,0));

    repeat (3) @(posedge clk);
    #1;
    checkField("reset.payValid", payValid, 1'b0);
    checkField("reset.payData", payData, 32'h0);
    checkField("reset.fsync", fsync, 1'b0);
    checkField("reset.lsync", lsync, 1'b0);
    checkField("reset.frameCnt", frameCnt, 16'h0);
    checkField("reset.lineCnt", lineCnt, 12'h0);
    checkField("reset.busy", busy, 1'b0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].data);
      checkOutput(vecs[i], i);
    end

    // RAW10 WC=40 with an idle cycle after every word: 10 payload words then one CRC word
    $display("[TB] streaming WC=40 line with gaps");
    pvCount = 0; byteSum = 0; lastCount = 0;
    applyStimulus(1, 1, 1, hdr(0, RAW10, 40));
    checkField("gap.hdrLsync", lsync, 1'b1);
    for (int w = 0; w < 11; w++) begin
      applyStimulus(1, 0, 1, 32'h01010101 * (w + 1));
      if (payValid) begin
        pvCount++;
        byteSum += payBytes;
        if (payLast) begin
          lastCount++;
          checkField("gap.lastIndex", w, 9);
        end
      end
      applyStimulus(0, 0, 1, 32'hFFFFFFFF);
      checkField($sformatf("gap%0d.idleValid", w), payValid, 1'b0);
    end
    waitCycles = 0;
    while (busy && waitCycles < 8) begin
      applyStimulus(0, 0, 1, 32'h0);
      waitCycles++;
    end
    checkField("gap.busyCleared", busy, 1'b0);
    checkField("gap.wordCount", pvCount, 10);
    checkField("gap.byteSum", byteSum, 40);
    checkField("gap.lastCount", lastCount, 1);
    checkField("gap.lineCnt", lineCnt, 12'd1);
    checkField("gap.lsync", lsync, 1'b0);

    // Header with ECC bit 0 flipped on an FS
    $display("[TB] FS with corrupted ECC");
    applyStimulus(1, 1, 1, hdr(0, 6'h01, 0));
    checkField("ecc.feFsync", fsync, 1'b0);
    badFs = hdr(0, 6'h00, 0) ^ 32'h01000000;
    applyStimulus(1, 1, 1, badFs);
`ifdef MIPI_ECC_CHECK_EN
    checkField("ecc.errEcc", errEcc, 1'b1);
    checkField("ecc.fsync", fsync, 1'b0);
    checkField("ecc.frameCnt", frameCnt, 16'd5);
`else
    checkField("ecc.errEcc", errEcc, 1'b0);
    checkField("ecc.fsync", fsync, 1'b1);
    checkField("ecc.frameCnt", frameCnt, 16'd6);
`endif
    applyStimulus(0, 0, 1, 32'h0);
    checkField("ecc.pulseEnds", errEcc, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
